// File: rtl/bresenham_line_engine.sv
// Bresenham line rasteriser: walks from (x0,y0) to (x1,y1) one pixel per accepted handshake.
// Optional macro BLE_PIXEL_COUNT_EN adds a 9-bit per-line pixel_count output.
module bresenham_line_engine (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       draw_en,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] x1,
  input  logic [7:0] y1,
  input  logic       pixel_ready,
  output logic [7:0] pixel_x,
  output logic [7:0] pixel_y,
  output logic       pixel_valid,
  output logic       draw_done,
  output logic       busy
`ifdef BLE_PIXEL_COUNT_EN
  ,
  output logic [8:0] pixel_count
`endif
);

  typedef enum logic [2:0] {IDLE, INIT, PLOT, DONE, REARM} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [7:0]        end_x_q, end_x_d, end_y_q, end_y_d;
  logic signed [10:0] err_q, err_d;
  logic signed [10:0] dx_q, dy_q;
  logic              sx_neg_q, sy_neg_q;
  logic [7:0]        pixel_x_q, pixel_y_q;
  logic              pixel_valid_q, draw_done_q, busy_q;

  logic [7:0]         abs_dx, abs_dy;
  logic signed [10:0] dx_init, dy_init;
  logic signed [11:0] e2, dx_ext, dy_ext;
  logic               step_x, step_y, at_end, accept;
  logic signed [10:0] err_step_x, err_step_y;

  // Deltas from the latched endpoints; cur still holds the start point during INIT.
  assign abs_dx  = (end_x_q >= cur_x_q) ? end_x_q - cur_x_q : cur_x_q - end_x_q;
  assign abs_dy  = (end_y_q >= cur_y_q) ? end_y_q - cur_y_q : cur_y_q - end_y_q;
  assign dx_init = $signed({3'b000, abs_dx});
  assign dy_init = 11'sd0 - $signed({3'b000, abs_dy});

  assign e2     = {err_q, 1'b0};
  assign dx_ext = dx_q;
  assign dy_ext = dy_q;
  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);
  assign err_step_x = step_x ? dy_q : 11'sd0;
  assign err_step_y = step_y ? dx_q : 11'sd0;
  assign at_end = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
  assign accept = (state_q == PLOT) && pixel_ready;

  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    end_x_d = end_x_q;
    end_y_d = end_y_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (draw_en) begin
          state_d = INIT;
          cur_x_d = x0;
          cur_y_d = y0;
          end_x_d = x1;
          end_y_d = y1;
        end
      end
      INIT: begin
        state_d = PLOT;
        err_d   = dx_init + dy_init;
      end
      PLOT: begin
        if (pixel_ready) begin
          if (at_end) begin
            state_d = DONE;
          end else begin
            err_d = err_q + err_step_x + err_step_y;
            if (step_x) cur_x_d = sx_neg_q ? cur_x_q - 8'd1 : cur_x_q + 8'd1;
            if (step_y) cur_y_d = sy_neg_q ? cur_y_q - 8'd1 : cur_y_q + 8'd1;
          end
        end
      end
      DONE:  state_d = REARM;
      REARM: if (!draw_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      cur_x_q       <= 8'd0;
      cur_y_q       <= 8'd0;
      end_x_q       <= 8'd0;
      end_y_q       <= 8'd0;
      err_q         <= 11'sd0;
      dx_q          <= 11'sd0;
      dy_q          <= 11'sd0;
      sx_neg_q      <= 1'b0;
      sy_neg_q      <= 1'b0;
      pixel_x_q     <= 8'd0;
      pixel_y_q     <= 8'd0;
      pixel_valid_q <= 1'b0;
      draw_done_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      end_x_q <= end_x_d;
      end_y_q <= end_y_d;
      err_q   <= err_d;
      if (state_q == INIT) begin
        dx_q     <= dx_init;
        dy_q     <= dy_init;
        sx_neg_q <= !(cur_x_q < end_x_q);
        sy_neg_q <= !(cur_y_q < end_y_q);
      end
      pixel_valid_q <= (state_d == PLOT);
      pixel_x_q     <= (state_d == PLOT) ? cur_x_d : 8'd0;
      pixel_y_q     <= (state_d == PLOT) ? cur_y_d : 8'd0;
      draw_done_q   <= (state_d == DONE);
      busy_q        <= (state_d != IDLE);
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pixel_valid = pixel_valid_q;
  assign draw_done   = draw_done_q;
  assign busy        = busy_q;

`ifdef BLE_PIXEL_COUNT_EN
  logic [8:0] pixel_count_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pixel_count_q <= 9'd0;
    end else if (state_q == IDLE && draw_en) begin
      pixel_count_q <= 9'd0;
    end else if (accept) begin
      pixel_count_q <= pixel_count_q + 9'd1;
    end
  end

  assign pixel_count = pixel_count_q;
`endif

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Directed self-checking bench for bresenham_line_engine with hand-computed pixel sequences.
`timescale 1ns/1ps
module tb_bresenham_line_engine;

  logic       clk;
  logic       n_rst;
  logic       draw_en;
  logic [7:0] x0, y0, x1, y1;
  logic       pixel_ready;
  logic [7:0] pixel_x, pixel_y;
  logic       pixel_valid, draw_done, busy;
`ifdef BLE_PIXEL_COUNT_EN
  logic [8:0] pixel_count;
`endif

  int checks = 0;
  int errors = 0;

  bresenham_line_engine dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .draw_en     (draw_en),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .pixel_ready (pixel_ready),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_valid (pixel_valid),
    .draw_done   (draw_done),
    .busy        (busy)
`ifdef BLE_PIXEL_COUNT_EN
    ,
    .pixel_count (pixel_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixel i of the expected sequence sits in byte i of exs/eys.
  task automatic draw_line(input logic [7:0] ax0, input logic [7:0] ay0,
                           input logic [7:0] ax1, input logic [7:0] ay1,
                           input int n, input logic [63:0] exs, input logic [63:0] eys,
                           input int hold);
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
    pixel_ready = 1'b1;
    draw_en = 1'b1;
    tick();
    check("init_busy", busy, 1);
    check("init_valid", pixel_valid, 0);
    // Scramble the endpoints: the latched line must not be disturbed.
    x0 = 8'd200; y0 = 8'd17; x1 = 8'd99; y1 = 8'd250;
    tick();
    for (int i = 0; i < n; i++) begin
      check($sformatf("pix%0d_valid", i), pixel_valid, 1);
      check($sformatf("pix%0d_x", i), pixel_x, exs[8*i +: 8]);
      check($sformatf("pix%0d_y", i), pixel_y, eys[8*i +: 8]);
      check($sformatf("pix%0d_done", i), draw_done, 0);
      tick();
    end
    check("done_pulse", draw_done, 1);
    check("done_valid", pixel_valid, 0);
    check("done_x", pixel_x, 0);
    check("done_y", pixel_y, 0);
`ifdef BLE_PIXEL_COUNT_EN
    check("pixel_count", pixel_count, n);
`endif
    for (int h = 0; h <= hold; h++) begin
      tick();
      check("rearm_busy", busy, 1);
      check("rearm_valid", pixel_valid, 0);
      check("rearm_done", draw_done, 0);
    end
    draw_en = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    $display("line (%0d,%0d)->(%0d,%0d) %0d pixels, hold %0d", ax0, ay0, ax1, ay1, n, hold);
  endtask

  initial begin
    n_rst = 1'b0; draw_en = 1'b0; pixel_ready = 1'b0;
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd0; y1 = 8'd0;
    tick(); tick();
    check("rst_valid", pixel_valid, 0);
    check("rst_done", draw_done, 0);
    check("rst_busy", busy, 0);
    check("rst_x", pixel_x, 0);
    check("rst_y", pixel_y, 0);
    n_rst = 1'b1;
    tick();

    // Horizontal line
    draw_line(8'd0, 8'd0, 8'd3, 8'd0, 4, 64'h03020100, 64'h0, 0);
    // Steep line going down-left
    draw_line(8'd5, 8'd5, 8'd3, 8'd1, 5, 64'h0303040405, 64'h0102030405, 0);
    // Single-pixel line
    draw_line(8'd7, 8'd7, 8'd7, 8'd7, 1, 64'h07, 64'h07, 0);
    // draw_en held 5 cycles past draw_done
    draw_line(8'd0, 8'd0, 8'd3, 8'd0, 4, 64'h03020100, 64'h0, 5);

    // Back-pressure on the second pixel of (0,0)->(2,2)
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd2; y1 = 8'd2;
    pixel_ready = 1'b1; draw_en = 1'b1;
    tick(); tick();
    check("bp_p0_x", pixel_x, 0);
    check("bp_p0_y", pixel_y, 0);
    tick();
    pixel_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", pixel_valid, 1);
      check("bp_hold_x", pixel_x, 1);
      check("bp_hold_y", pixel_y, 1);
      tick();
    end
    check("bp_p1_x", pixel_x, 1);
    pixel_ready = 1'b1;
    tick();
    check("bp_p2_x", pixel_x, 2);
    check("bp_p2_y", pixel_y, 2);
    tick();
    check("bp_done", draw_done, 1);
    draw_en = 1'b0;
    tick(); tick();
    check("bp_idle", busy, 0);
    $display("line (0,0)->(2,2) with back-pressure");

    // Reset in the middle of (0,0)->(10,0)
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd10; y1 = 8'd0;
    pixel_ready = 1'b1; draw_en = 1'b1;
    tick(); tick(); tick();
    check("mid_p1_x", pixel_x, 1);
    n_rst = 1'b0;
    tick();
    check("mid_rst_valid", pixel_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_x", pixel_x, 0);
    check("mid_rst_done", draw_done, 0);
    n_rst = 1'b1; draw_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_done", draw_done, 0);
      check("post_rst_valid", pixel_valid, 0);
    end
    $display("line (0,0)->(10,0) abandoned by reset");
    draw_line(8'd1, 8'd1, 8'd2, 8'd1, 2, 64'h0201, 64'h0101, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bresenham_line_engine.md
BRESENHAM_LINE_ENGINE -- requirements
Module: bresenham_line_engine

Interface
REQ-001 SHALL have one clock and reset, ordered first: clk input 1 rising-edge clock; n_rst input 1 reset, synchronous and active-low.
REQ-002 SHALL have draw_en input 1: draw request, held high by the requester until draw_done is seen.
REQ-003 SHALL have x0, y0, x1, y1 inputs, 8 bits each, unsigned: line endpoints, valid while draw_en is high.
REQ-004 SHALL have pixel_ready input 1: downstream pixel sink can accept a pixel.
REQ-005 SHALL have pixel_x, pixel_y outputs, 8 bits each: current pixel coordinate.
REQ-006 SHALL have pixel_valid output 1: pixel_x/pixel_y hold a valid pixel.
REQ-007 SHALL have draw_done output 1: single-cycle pulse when the line is complete.
REQ-008 SHALL have busy output 1: high in every state except IDLE.

Function
REQ-009 SHALL use states IDLE, INIT, PLOT, DONE, REARM.
REQ-010 IDLE: if draw_en=1, SHALL latch x0/y0/x1/y1 and go to INIT; otherwise stay in IDLE.
REQ-011 INIT: SHALL compute the following, then go to PLOT:
- dx=|x1-x0|, dy=-|y1-y0|
- sx=+1 if x0<x1 else -1; sy=+1 if y0<y1 else -1
- err=dx+dy, as an 11-bit signed value
- cur=(x0,y0)
REQ-012 PLOT: pixel_valid SHALL be 1 and pixel_x/pixel_y SHALL equal cur; the first pixel appears 2 cycles after draw_en is sampled in IDLE.
REQ-013 A pixel is accepted when pixel_valid=1 and pixel_ready=1 in the same cycle; without acceptance, cur, err and the state SHALL hold.
REQ-014 On acceptance, if cur==(x1,y1): SHALL go to DONE. Otherwise, with e2=2*err (12-bit signed), both tests evaluated on the pre-update err:
- if e2>=dy: err+=dy, x+=sx
- if e2<=dx: err+=dx, y+=sy
REQ-015 A line SHALL emit exactly max(dx,|dy|)+1 pixels, with no duplicate pixels and no skipped pixels.
REQ-016 x0==x1 and y0==y1 SHALL emit exactly one pixel, (x0,y0).
REQ-017 DONE: draw_done=1 and pixel_valid=0 for exactly one cycle, then go to REARM.
REQ-018 REARM: SHALL stay until draw_en=0, then go to IDLE; a draw_en held high SHALL never start a second line.
REQ-019 Changes on x0..y1 after the IDLE->INIT transition SHALL have no effect on the line in progress.
REQ-020 pixel_x/pixel_y SHALL be 0 whenever pixel_valid=0.
REQ-021 Coordinate arithmetic SHALL never wrap: cur stays within the 0..255 bounding box of the endpoints.

Reset
REQ-022 While n_rst=0 at a clk edge, the state SHALL become IDLE and pixel_valid, draw_done, busy, pixel_x, pixel_y SHALL all be 0.
REQ-023 Reset mid-line SHALL abandon the line: no further pixels and no draw_done for it.
REQ-024 After reset, the first draw_en=1 sampled SHALL start a new line normally.

Configuration
REQ-025 With macro BLE_PIXEL_COUNT_EN defined, SHALL add output pixel_count (9 bits) with this behaviour:
- cleared to 0 on IDLE->INIT and on reset
- incremented on each accepted pixel
- held through DONE/REARM/IDLE until the next line starts
REQ-026 Without BLE_PIXEL_COUNT_EN, SHALL have no pixel_count port and no counter logic; all other behaviour is identical.

Verification
REQ-027 (0,0)->(3,0), pixel_ready=1 -> pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles; draw_done for one cycle; pixel_count=4 if enabled.
REQ-028 (5,5)->(3,1), pixel_ready=1 -> pixels (5,5),(4,4),(4,3),(3,2),(3,1), then draw_done.
REQ-029 (7,7)->(7,7) -> single pixel (7,7), then draw_done on the next cycle.
REQ-030 (0,0)->(2,2), pixel_ready low for 3 cycles at the 2nd pixel -> (1,1) held stable for 3 cycles; sequence (0,0),(1,1),(2,2) unchanged.
REQ-031 n_rst=0 after the 2nd pixel of (0,0)->(10,0) -> all outputs 0 next cycle; no draw_done; a new line (1,1)->(2,1) then emits (1,1),(2,1).
REQ-032 draw_en held high 5 cycles past draw_done -> busy=1 in REARM, no pixels; draw_en low one cycle -> IDLE, busy=0.
